fp_addsub_pipe: RTL

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined IEEE-754-style adder/subtractor, round to nearest even.
// Subnormal operands and results are flushed to signed zero.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] s,
  output logic [3:0]           flags
);
  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int M       = MAN_W + 3;  // hidden, mantissa, guard, round
  localparam int X       = MAN_W + 4;  // M plus sticky
  localparam int LZW     = $clog2(X + 1);
  localparam int EW      = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic signA, signB, nanA, nanB, infA, infB, zeroA, zeroB, aBig;
  logic [EXP_W-1:0] expA, expB;
  logic [MAN_W-1:0] manA, manB;
  logic c1Special, c1Invalid;
  logic [W-1:0] c1SpecRes;

  // Unpack, flush subnormals, resolve every special-operand case up front.
  always_comb begin
    signA     = a[W-1];
    signB     = b[W-1] ^ op;
    expA      = a[W-2:MAN_W];
    expB      = b[W-2:MAN_W];
    zeroA     = (expA == '0);
    zeroB     = (expB == '0);
    manA      = zeroA ? '0 : a[MAN_W-1:0];
    manB      = zeroB ? '0 : b[MAN_W-1:0];
    nanA      = (expA == EXP_ONES) && (manA != '0);
    nanB      = (expB == EXP_ONES) && (manB != '0);
    infA      = (expA == EXP_ONES) && (manA == '0);
    infB      = (expB == EXP_ONES) && (manB == '0);
    aBig      = {expA, manA} >= {expB, manB};
    c1Special = 1'b1;
    c1Invalid = 1'b0;
    c1SpecRes = QNAN;
    if (nanA || nanB)
      c1Invalid = (nanA && !manA[MAN_W-1]) || (nanB && !manB[MAN_W-1]);
    else if (infA && infB && (signA != signB))
      c1Invalid = 1'b1;
    else if (infA)
      c1SpecRes = {signA, EXP_ONES, {MAN_W{1'b0}}};
    else if (infB)
      c1SpecRes = {signB, EXP_ONES, {MAN_W{1'b0}}};
    else if (zeroA && zeroB)
      c1SpecRes = {signA & signB, {(W-1){1'b0}}};
    else
      c1Special = 1'b0;
  end

  logic s1Valid, s1Special, s1Invalid, s1Sign, s1Sub;
  logic [W-1:0] s1SpecRes;
  logic [EXP_W-1:0] s1ExpL, s1ExpS;
  logic [MAN_W:0] s1ManL, s1ManS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid   <= 1'b0;
      s1Special <= 1'b0;
      s1Invalid <= 1'b0;
      s1Sign    <= 1'b0;
      s1Sub     <= 1'b0;
      s1SpecRes <= '0;
      s1ExpL    <= '0;
      s1ExpS    <= '0;
      s1ManL    <= '0;
      s1ManS    <= '0;
    end else if (en) begin
      s1Valid   <= in_valid;
      s1Special <= c1Special;
      s1Invalid <= c1Invalid;
      s1SpecRes <= c1SpecRes;
      s1Sign    <= aBig ? signA : signB;
      s1Sub     <= (signA != signB);
      s1ExpL    <= aBig ? expA : expB;
      s1ExpS    <= aBig ? expB : expA;
      s1ManL    <= aBig ? {!zeroA, manA} : {!zeroB, manB};
      s1ManS    <= aBig ? {!zeroB, manB} : {!zeroA, manA};
    end
  end

  logic [EXP_W-1:0] c2Diff;
  logic [M-1:0] c2Wide, c2Shifted;
  logic c2Sticky;

  // Align the smaller operand; everything shifted out collapses into sticky.
  always_comb begin
    c2Diff = s1ExpL - s1ExpS;
    c2Wide = {s1ManS, 2'b00};
    if (int'(c2Diff) >= M) begin
      c2Shifted = '0;
      c2Sticky  = |c2Wide;
    end else begin
      c2Shifted = c2Wide >> c2Diff;
      c2Sticky  = |(c2Wide & ~({M{1'b1}} << c2Diff));
    end
  end

  logic s2Valid, s2Special, s2Invalid, s2Sign, s2Sub;
  logic [W-1:0] s2SpecRes;
  logic [EXP_W-1:0] s2Exp;
  logic [X-1:0] s2MantL, s2MantS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid   <= 1'b0;
      s2Special <= 1'b0;
      s2Invalid <= 1'b0;
      s2Sign    <= 1'b0;
      s2Sub     <= 1'b0;
      s2SpecRes <= '0;
      s2Exp     <= '0;
      s2MantL   <= '0;
      s2MantS   <= '0;
    end else if (en) begin
      s2Valid   <= s1Valid;
      s2Special <= s1Special;
      s2Invalid <= s1Invalid;
      s2SpecRes <= s1SpecRes;
      s2Sign    <= s1Sign;
      s2Sub     <= s1Sub;
      s2Exp     <= s1ExpL;
      s2MantL   <= {s1ManL, 3'b000};
      s2MantS   <= {c2Shifted, c2Sticky};
    end
  end

  logic [X:0] c3Sum;
  logic [X-1:0] c3Norm;
  logic [LZW-1:0] c3Lz;
  logic signed [EW-1:0] c3Exp;
  logic c3Zero;

  // The larger operand is always first, so subtraction never goes negative.
  always_comb begin
    c3Sum = s2Sub ? ({1'b0, s2MantL} - {1'b0, s2MantS})
                  : ({1'b0, s2MantL} + {1'b0, s2MantS});
    c3Zero = (c3Sum == '0);
    c3Lz   = '0;
    for (int i = 0; i < X; i++)
      if (c3Sum[i]) c3Lz = LZW'(X - 1 - i);
    if (c3Sum[X]) begin
      c3Norm = {c3Sum[X:2], c3Sum[1] | c3Sum[0]};
      c3Exp  = EW'(s2Exp) + EW'(1);
    end else begin
      c3Norm = c3Sum[X-1:0] << c3Lz;
      c3Exp  = EW'(s2Exp) - EW'(c3Lz);
    end
  end

  logic s3Valid, s3Special, s3Invalid, s3Sign, s3Zero;
  logic [W-1:0] s3SpecRes;
  logic signed [EW-1:0] s3Exp;
  logic [X-1:0] s3Mant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3Valid   <= 1'b0;
      s3Special <= 1'b0;
      s3Invalid <= 1'b0;
      s3Sign    <= 1'b0;
      s3Zero    <= 1'b0;
      s3SpecRes <= '0;
      s3Exp     <= '0;
      s3Mant    <= '0;
    end else if (en) begin
      s3Valid   <= s2Valid;
      s3Special <= s2Special;
      s3Invalid <= s2Invalid;
      s3SpecRes <= s2SpecRes;
      s3Sign    <= s2Sign;
      s3Zero    <= c3Zero;
      s3Exp     <= c3Exp;
      s3Mant    <= c3Norm;
    end
  end

  logic c4Up, c4Inexact;
  logic [MAN_W+1:0] c4Rounded;
  logic signed [EW-1:0] c4Exp;
  logic [W-1:0] c4Res;
  logic [3:0] c4Flags;

  // Round on guard/round/sticky, then pick special, zero, flush, overflow or normal.
  always_comb begin
    c4Inexact = |s3Mant[2:0];
    c4Up      = s3Mant[2] && (s3Mant[1] || s3Mant[0] || s3Mant[3]);
    c4Rounded = {1'b0, s3Mant[X-1:3]} + (MAN_W+2)'(c4Up);
    c4Exp     = c4Rounded[MAN_W+1] ? s3Exp + EW'(1) : s3Exp;
    c4Res     = {s3Sign, c4Exp[EXP_W-1:0],
                 c4Rounded[MAN_W+1] ? c4Rounded[MAN_W:1] : c4Rounded[MAN_W-1:0]};
    c4Flags   = {3'b000, c4Inexact};
    if (s3Special) begin
      c4Res   = s3SpecRes;
      c4Flags = {s3Invalid, 3'b000};
    end else if (s3Zero) begin
      c4Res   = '0;
      c4Flags = 4'b0000;
    end else if (s3Exp <= EW'(0)) begin
      c4Res   = {s3Sign, {(W-1){1'b0}}};
      c4Flags = 4'b0011;
    end else if (c4Exp >= EW'(EXP_MAX)) begin
      c4Res   = {s3Sign, EXP_ONES, {MAN_W{1'b0}}};
      c4Flags = 4'b0101;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      flags     <= '0;
    end else if (en) begin
      out_valid <= s3Valid;
      s         <= c4Res;
      flags     <= c4Flags;
    end
  end

endmodule
